// File: rtl/cpu_seq_ctrl_if.sv
// Control and status bundle between the multicycle sequencer (master) and the RISC datapath (slave).
interface cpu_seq_ctrl_if;
  logic [2:0] opcode;
  logic [1:0] alu_op;
  logic [2:0] cond;
  logic       Z, N, V;
  logic       mem_rdy;
  logic [1:0] reg_sel;
  logic [1:0] wb_sel;
  logic       w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic       clear_pc, load_pc, pc_src;
  logic       load_ir, load_addr, sel_addr;
  logic       mem_req, mem_we;

  modport master (
    input  opcode, alu_op, cond, Z, N, V, mem_rdy,
    output reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
           clear_pc, load_pc, pc_src, load_ir, load_addr, sel_addr, mem_req, mem_we
  );

  modport slave (
    output opcode, alu_op, cond, Z, N, V, mem_rdy,
    input  reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
           clear_pc, load_pc, pc_src, load_ir, load_addr, sel_addr, mem_req, mem_we
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multicycle control FSM for the simple RISC datapath: memory wait/timeout,
// conditional branches, sticky fault state and a retired-instruction counter.
module cpu_seq_ctrl #(
  parameter int RET_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter bit BRANCH_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_seq_ctrl_if.master       bus,
  output logic                 waiting,
  output logic                 fault,
  output logic [RET_W-1:0]     retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_LOAD_IR, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WB,
    S_WB_IMM, S_ADDR, S_LATCH, S_MEM_RD, S_WB_MEM, S_GET_D, S_PASS, S_MEM_WR,
    S_BRANCH, S_HALT, S_FAULT
  } state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [RET_W-1:0]  retired_reg;
  logic              retire;
  logic              in_wait, timed_out;
  logic              br_valid, br_taken;
  logic [4:0]        ir;
  logic              is_mov_like, is_cmp, is_ldr, is_str, is_alu;

  assign ir          = {bus.opcode, bus.alu_op};
  assign is_alu      = (bus.opcode == 3'b101);
  assign is_mov_like = (ir == 5'b11000) || (ir == 5'b10111);
  assign is_cmp      = (ir == 5'b10101);
  assign is_ldr      = (ir == 5'b01100);
  assign is_str      = (ir == 5'b10000);
  assign in_wait     = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) || (state_reg == S_MEM_WR);
  // A ready response in the limit cycle still completes the access.
  assign timed_out   = (MEM_TIMEOUT > 0) && !bus.mem_rdy && (wait_cnt_reg == WAIT_LIMIT);
  assign retired     = retired_reg;

  always_comb begin
    br_valid = 1'b1;
    br_taken = 1'b0;
    case (bus.cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = bus.Z;
      3'b010:  br_taken = !bus.Z;
      3'b011:  br_taken = bus.N ^ bus.V;
      3'b100:  br_taken = (bus.N ^ bus.V) | bus.Z;
      default: br_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_RST;
      wait_cnt_reg <= '0;
      retired_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (in_wait && !bus.mem_rdy)
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      if (retire)
        retired_reg <= retired_reg + RET_W'(1);
    end
  end

  always_comb begin
    state_next    = state_reg;
    retire        = 1'b0;
    waiting       = 1'b0;
    fault         = 1'b0;
    bus.reg_sel   = 2'b00;
    bus.wb_sel    = 2'b00;
    bus.w_en      = 1'b0;
    bus.en_A      = 1'b0;
    bus.en_B      = 1'b0;
    bus.en_C      = 1'b0;
    bus.en_status = 1'b0;
    bus.sel_A     = 1'b0;
    bus.sel_B     = 1'b0;
    bus.clear_pc  = 1'b0;
    bus.load_pc   = 1'b0;
    bus.pc_src    = 1'b0;
    bus.load_ir   = 1'b0;
    bus.load_addr = 1'b0;
    bus.sel_addr  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    case (state_reg)
      S_RST: begin
        waiting      = 1'b1;
        bus.clear_pc = 1'b1;
        bus.load_pc  = 1'b1;
        state_next   = S_FETCH;
      end
      S_FETCH: begin
        bus.sel_addr = 1'b1;
        bus.mem_req  = 1'b1;
        if (bus.mem_rdy)    state_next = S_LOAD_IR;
        else if (timed_out) state_next = S_FAULT;
      end
      S_LOAD_IR: begin
        bus.load_ir = 1'b1;
        bus.load_pc = 1'b1;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        if (bus.opcode == 3'b111)                      state_next = S_HALT;
        else if (ir == 5'b11010)                       state_next = S_WB_IMM;
        else if (is_mov_like)                          state_next = S_GET_B;
        else if (is_alu || is_ldr || is_str)           state_next = S_GET_A;
        else if (BRANCH_EN && (bus.opcode == 3'b001))  state_next = S_BRANCH;
        else                                           state_next = S_FAULT;
      end
      S_GET_A: begin
        bus.reg_sel = 2'b10;
        bus.en_A    = 1'b1;
        state_next  = is_alu ? S_GET_B : S_ADDR;
      end
      S_GET_B: begin
        bus.en_B   = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        bus.sel_A = is_mov_like;
        if (is_cmp) begin
          bus.en_status = 1'b1;
          retire        = 1'b1;
          state_next    = S_FETCH;
        end else begin
          bus.en_C   = 1'b1;
          state_next = S_WB;
        end
      end
      S_WB: begin
        bus.w_en    = 1'b1;
        bus.reg_sel = 2'b01;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_WB_IMM: begin
        bus.w_en    = 1'b1;
        bus.reg_sel = 2'b10;
        bus.wb_sel  = 2'b10;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_ADDR: begin
        bus.sel_B  = 1'b1;
        bus.en_C   = 1'b1;
        state_next = S_LATCH;
      end
      S_LATCH: begin
        bus.load_addr = 1'b1;
        state_next    = is_ldr ? S_MEM_RD : S_GET_D;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        if (bus.mem_rdy)    state_next = S_WB_MEM;
        else if (timed_out) state_next = S_FAULT;
      end
      S_WB_MEM: begin
        bus.w_en    = 1'b1;
        bus.reg_sel = 2'b01;
        bus.wb_sel  = 2'b11;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_GET_D: begin
        bus.reg_sel = 2'b01;
        bus.en_B    = 1'b1;
        state_next  = S_PASS;
      end
      S_PASS: begin
        bus.sel_A  = 1'b1;
        bus.en_C   = 1'b1;
        state_next = S_MEM_WR;
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_rdy) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (timed_out) begin
          state_next = S_FAULT;
        end
      end
      S_BRANCH: begin
        if (br_valid) begin
          bus.load_pc = br_taken;
          bus.pc_src  = br_taken;
          retire      = 1'b1;
          state_next  = S_FETCH;
        end else begin
          state_next = S_FAULT;
        end
      end
      S_HALT: waiting = 1'b1;
      S_FAULT: begin
        waiting = 1'b1;
        fault   = 1'b1;
      end
      default: state_next = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomised bench for cpu_seq_ctrl: a per-instruction reference model expands each
// instruction into the expected per-cycle control word and retire effect.
module tb_cpu_seq_ctrl;

  localparam int MEM_TO = 15;

  localparam logic [20:0] K_WAITB = 21'd1 << 20;
  localparam logic [20:0] K_RS01  = 21'd1 << 18;
  localparam logic [20:0] K_RS10  = 21'd2 << 18;
  localparam logic [20:0] K_WB10  = 21'd2 << 16;
  localparam logic [20:0] K_WB11  = 21'd3 << 16;
  localparam logic [20:0] K_WEN   = 21'd1 << 15;
  localparam logic [20:0] K_ENA   = 21'd1 << 14;
  localparam logic [20:0] K_ENB   = 21'd1 << 13;
  localparam logic [20:0] K_ENC   = 21'd1 << 12;
  localparam logic [20:0] K_ENS   = 21'd1 << 11;
  localparam logic [20:0] K_SELA  = 21'd1 << 10;
  localparam logic [20:0] K_SELB  = 21'd1 << 9;
  localparam logic [20:0] K_CLR   = 21'd1 << 8;
  localparam logic [20:0] K_LPC   = 21'd1 << 7;
  localparam logic [20:0] K_PCSRC = 21'd1 << 6;
  localparam logic [20:0] K_LDIR  = 21'd1 << 5;
  localparam logic [20:0] K_LADDR = 21'd1 << 4;
  localparam logic [20:0] K_SADDR = 21'd1 << 3;
  localparam logic [20:0] K_REQ   = 21'd1 << 2;
  localparam logic [20:0] K_WE    = 21'd1 << 1;
  localparam logic [20:0] K_FLTB  = 21'd1;

  localparam logic [20:0] K_NONE  = 21'd0;
  localparam logic [20:0] K_RST   = K_WAITB | K_CLR | K_LPC;
  localparam logic [20:0] K_FET   = K_SADDR | K_REQ;
  localparam logic [20:0] K_LIR   = K_LDIR | K_LPC;
  localparam logic [20:0] K_GETA  = K_RS10 | K_ENA;
  localparam logic [20:0] K_GETB  = K_ENB;
  localparam logic [20:0] K_EXCMP = K_ENS;
  localparam logic [20:0] K_EXALU = K_ENC;
  localparam logic [20:0] K_EXMOV = K_ENC | K_SELA;
  localparam logic [20:0] K_WB    = K_WEN | K_RS01;
  localparam logic [20:0] K_WBI   = K_WEN | K_RS10 | K_WB10;
  localparam logic [20:0] K_ADDR  = K_SELB | K_ENC;
  localparam logic [20:0] K_LATCH = K_LADDR;
  localparam logic [20:0] K_MEMRD = K_REQ;
  localparam logic [20:0] K_WBMEM = K_WEN | K_RS01 | K_WB11;
  localparam logic [20:0] K_GETD  = K_RS01 | K_ENB;
  localparam logic [20:0] K_PASS  = K_SELA | K_ENC;
  localparam logic [20:0] K_MEMWR = K_REQ | K_WE;
  localparam logic [20:0] K_BRT   = K_LPC | K_PCSRC;
  localparam logic [20:0] K_HALT  = K_WAITB;
  localparam logic [20:0] K_FLT   = K_WAITB | K_FLTB;

  typedef struct {
    logic [2:0] op;
    logic [1:0] aop;
    logic [2:0] cnd;
    logic       z, n, v;
    int         fd, md;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        waiting, fault, waiting2, fault2;
  logic [15:0] retired;
  logic [1:0]  retired2;
  logic [20:0] ctl1, ctl2;

  int n_cmp = 0;
  int n_bad = 0;
  int ret_model = 0;
  int ret_before = 0;

  logic [20:0] q_w[$];
  bit          q_r[$];
  logic [20:0] o_w[$];
  logic [20:0] o_w2[$];
  logic [15:0] o_ret[$];
  logic [1:0]  o_ret2[$];

  always #5 clk = ~clk;

  cpu_seq_ctrl_if bus ();
  cpu_seq_ctrl_if bus2 ();

  assign bus2.opcode  = bus.opcode;
  assign bus2.alu_op  = bus.alu_op;
  assign bus2.cond    = bus.cond;
  assign bus2.Z       = bus.Z;
  assign bus2.N       = bus.N;
  assign bus2.V       = bus.V;
  assign bus2.mem_rdy = bus.mem_rdy;

  cpu_seq_ctrl #(.RET_W(16), .MEM_TIMEOUT(MEM_TO), .BRANCH_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .waiting(waiting), .fault(fault), .retired(retired)
  );

  cpu_seq_ctrl #(.RET_W(2), .MEM_TIMEOUT(MEM_TO), .BRANCH_EN(1'b1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master),
    .waiting(waiting2), .fault(fault2), .retired(retired2)
  );

  assign ctl1 = {waiting, bus.reg_sel, bus.wb_sel, bus.w_en, bus.en_A, bus.en_B, bus.en_C,
                 bus.en_status, bus.sel_A, bus.sel_B, bus.clear_pc, bus.load_pc, bus.pc_src,
                 bus.load_ir, bus.load_addr, bus.sel_addr, bus.mem_req, bus.mem_we, fault};
  assign ctl2 = {waiting2, bus2.reg_sel, bus2.wb_sel, bus2.w_en, bus2.en_A, bus2.en_B, bus2.en_C,
                 bus2.en_status, bus2.sel_A, bus2.sel_B, bus2.clear_pc, bus2.load_pc, bus2.pc_src,
                 bus2.load_ir, bus2.load_addr, bus2.sel_addr, bus2.mem_req, bus2.mem_we, fault2};

  function automatic instr_t mk(input logic [4:0] key, input logic [2:0] cnd,
                                input logic z, input logic n, input logic v,
                                input int fd, input int md);
    instr_t t;
    {t.op, t.aop} = key;
    t.cnd = cnd; t.z = z; t.n = n; t.v = v; t.fd = fd; t.md = md;
    return t;
  endfunction

  function automatic instr_t rand_legal();
    instr_t t;
    logic [4:0] keys [9];
    keys = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b01100, 5'b10000, 5'b00100};
    t = mk(keys[$urandom_range(0, 8)], 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4));
    if (t.op == 3'b001) t.aop = 2'($urandom_range(0, 3));
    return t;
  endfunction

  // Model: one expected control word per cycle, plus the random mem_rdy to drive in that cycle.
  task automatic push(input logic [20:0] w);
    q_w.push_back(w);
    q_r.push_back($urandom_range(0, 1) != 0);
  endtask

  task automatic push_wait(input logic [20:0] w, input int d, output bit to);
    to = (d > MEM_TO);
    if (to) begin
      for (int i = 0; i <= MEM_TO; i++) begin q_w.push_back(w); q_r.push_back(1'b0); end
    end else begin
      for (int i = 0; i < d; i++) begin q_w.push_back(w); q_r.push_back(1'b0); end
      q_w.push_back(w); q_r.push_back(1'b1);
    end
  endtask

  task automatic build(input instr_t t, output int inc, output int term);
    logic [4:0] key;
    bit to, lt, tk;
    key = {t.op, t.aop};
    inc = 0; term = 0;
    q_w.delete(); q_r.delete();
    push_wait(K_FET, t.fd, to);
    if (to) term = 2;
    else begin
      push(K_LIR); push(K_NONE);
      if (t.op == 3'b111) term = 1;
      else if (key == 5'b11010) begin push(K_WBI); inc = 1; end
      else if (key == 5'b11000 || key == 5'b10111) begin
        push(K_GETB); push(K_EXMOV); push(K_WB); inc = 1;
      end else if (t.op == 3'b101) begin
        push(K_GETA); push(K_GETB);
        if (t.aop == 2'b01) push(K_EXCMP);
        else begin push(K_EXALU); push(K_WB); end
        inc = 1;
      end else if (key == 5'b01100 || key == 5'b10000) begin
        push(K_GETA); push(K_ADDR); push(K_LATCH);
        if (key == 5'b01100) begin
          push_wait(K_MEMRD, t.md, to);
          if (!to) push(K_WBMEM);
        end else begin
          push(K_GETD); push(K_PASS); push_wait(K_MEMWR, t.md, to);
        end
        if (to) term = 2; else inc = 1;
      end else if (t.op == 3'b001) begin
        lt = (t.n != t.v);
        case (t.cnd)
          3'd0:    tk = 1'b1;
          3'd1:    tk = t.z;
          3'd2:    tk = !t.z;
          3'd3:    tk = lt;
          3'd4:    tk = lt || t.z;
          default: tk = 1'b0;
        endcase
        push(tk ? K_BRT : K_NONE);
        if (t.cnd > 3'd4) term = 2; else inc = 1;
      end else term = 2;
    end
    if (term == 1) repeat (3) push(K_HALT);
    if (term == 2) repeat (3) push(K_FLT);
  endtask

  task automatic apply_instr(input instr_t t);
    @(posedge clk); #1;
    bus.opcode = t.op; bus.alu_op = t.aop; bus.cond = t.cnd;
    bus.Z = t.z; bus.N = t.n; bus.V = t.v;
  endtask

  task automatic run_instr(input instr_t t, output int term);
    int inc;
    build(t, inc, term);
    apply_instr(t);
    o_w.delete(); o_w2.delete(); o_ret.delete(); o_ret2.delete();
    foreach (q_r[i]) begin
      @(negedge clk);
      bus.mem_rdy = q_r[i];
      #1;
      o_w.push_back(ctl1); o_w2.push_back(ctl2);
      o_ret.push_back(retired); o_ret2.push_back(retired2);
    end
    ret_before = ret_model;
    ret_model += inc;
    $display("instr op=%b alu=%b cond=%b ZNV=%b%b%b fd=%0d md=%0d cycles=%0d end=%0d retired=%0d",
             t.op, t.aop, t.cnd, t.z, t.n, t.v, t.fd, t.md, q_w.size(), term, ret_model);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.mem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ret_model = 0;
  endtask

  task automatic test_reset();
    instr_t t;
    int term, inc;
    rst = 1'b1; bus.mem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ctl1 !== K_RST || retired !== 16'd0) begin
      n_bad++; $display("FAIL por_state ctl got %h want %h retired got %0d want 0", ctl1, K_RST, retired);
    end
    rst = 1'b0; ret_model = 0;
    run_instr(mk(5'b11010, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0), term);
    foreach (q_w[i]) begin
      n_cmp++; if (o_w[i] !== q_w[i]) begin
        n_bad++; $display("FAIL reset_mov step %0d ctl got %h want %h", i, o_w[i], q_w[i]);
      end
    end
    // LDR stuck in MEM_RD, interrupted by reset after two wait cycles.
    t = mk(5'b01100, 3'd0, 1'b0, 1'b0, 1'b0, 0, 100);
    build(t, inc, term);
    apply_instr(t);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus.mem_rdy = q_r[i]; #1;
      n_cmp++; if (ctl1 !== q_w[i] || retired !== 16'd1) begin
        n_bad++; $display("FAIL reset_ldr step %0d ctl got %h want %h retired got %0d want 1", i, ctl1, q_w[i], retired);
      end
    end
    @(negedge clk); rst = 1'b1; bus.mem_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (ctl1 !== K_RST || ctl2 !== K_RST) begin
        n_bad++; $display("FAIL mid_reset cycle %0d ctl got %h/%h want %h", i, ctl1, ctl2, K_RST);
      end
      n_cmp++; if (retired !== 16'd0 || retired2 !== 2'd0) begin
        n_bad++; $display("FAIL mid_reset cycle %0d retired got %0d/%0d want 0", i, retired, retired2);
      end
    end
    rst = 1'b0; ret_model = 0;
    @(negedge clk); #1;
    n_cmp++; if (ctl1 !== K_FET) begin
      n_bad++; $display("FAIL post_reset_fetch ctl got %h want %h", ctl1, K_FET);
    end
  endtask

  task automatic test_back_to_back();
    int term;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      run_instr(rand_legal(), term);
      foreach (q_w[i]) begin
        n_cmp++; if (o_w[i] !== q_w[i] || o_w2[i] !== q_w[i]) begin
          n_bad++; $display("FAIL b2b instr %0d step %0d ctl got %h/%h want %h", k, i, o_w[i], o_w2[i], q_w[i]);
        end
        n_cmp++; if (o_ret[i] !== 16'(ret_before) || o_ret2[i] !== 2'(ret_before)) begin
          n_bad++; $display("FAIL b2b_retired instr %0d step %0d got %0d/%0d want %0d", k, i, o_ret[i], o_ret2[i], ret_before);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int term;
    instr_t cases [6];
    cases[0] = mk(5'b01100, 3'd0, 1'b0, 1'b0, 1'b0, 0, 3);
    cases[1] = mk(5'b01100, 3'd0, 1'b0, 1'b0, 1'b0, 1, MEM_TO);
    cases[2] = mk(5'b01100, 3'd0, 1'b0, 1'b0, 1'b0, 0, MEM_TO + 1);
    cases[3] = mk(5'b10000, 3'd0, 1'b0, 1'b0, 1'b0, 2, 40);
    cases[4] = mk(5'b10110, 3'd0, 1'b0, 1'b0, 1'b0, MEM_TO, 0);
    cases[5] = mk(5'b10110, 3'd0, 1'b0, 1'b0, 1'b0, MEM_TO + 1, 0);
    foreach (cases[k]) begin
      do_reset();
      run_instr(cases[k], term);
      foreach (q_w[i]) begin
        n_cmp++; if (o_w[i] !== q_w[i] || o_w2[i] !== q_w[i]) begin
          n_bad++; $display("FAIL timeout case %0d step %0d ctl got %h/%h want %h", k, i, o_w[i], o_w2[i], q_w[i]);
        end
      end
      n_cmp++; if (o_ret[o_ret.size()-1] !== 16'(ret_before)) begin
        n_bad++; $display("FAIL timeout_retired case %0d got %0d want %0d", k, o_ret[o_ret.size()-1], ret_before);
      end
    end
  endtask

  task automatic test_branch();
    int term;
    instr_t t;
    for (int k = 0; k < 28; k++) begin
      if (k == 0 || term != 0) do_reset();
      case (k)
        0:       t = mk(5'b00100, 3'd1, 1'b1, 1'b0, 1'b0, 0, 0);
        1:       t = mk(5'b00100, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);
        2:       t = mk(5'b00100, 3'd6, 1'b1, 1'b1, 1'b0, 0, 0);
        default: t = mk(5'b00100, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
      endcase
      run_instr(t, term);
      foreach (q_w[i]) begin
        n_cmp++; if (o_w[i] !== q_w[i] || o_w2[i] !== q_w[i]) begin
          n_bad++; $display("FAIL branch %0d cond=%b step %0d ctl got %h/%h want %h", k, t.cnd, i, o_w[i], o_w2[i], q_w[i]);
        end
        n_cmp++; if (o_ret[i] !== 16'(ret_before)) begin
          n_bad++; $display("FAIL branch_retired %0d step %0d got %0d want %0d", k, i, o_ret[i], ret_before);
        end
      end
    end
  endtask

  task automatic test_illegal_halt();
    int term;
    logic [4:0] keys [11];
    keys = '{5'b00000, 5'b00011, 5'b01000, 5'b01101, 5'b01111, 5'b10001,
             5'b10011, 5'b11001, 5'b11011, 5'b11100, 5'b11111};
    foreach (keys[k]) begin
      do_reset();
      run_instr(mk(5'b11010, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0), term);
      run_instr(mk(keys[k], 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0, $urandom_range(0, 2), 0), term);
      foreach (q_w[i]) begin
        n_cmp++; if (o_w[i] !== q_w[i]) begin
          n_bad++; $display("FAIL illegal key=%b step %0d ctl got %h want %h", keys[k], i, o_w[i], q_w[i]);
        end
        n_cmp++; if (o_ret[i] !== 16'd1) begin
          n_bad++; $display("FAIL illegal_retired key=%b step %0d got %0d want 1", keys[k], i, o_ret[i]);
        end
      end
    end
  endtask

  task automatic test_retired_wrap();
    int term;
    do_reset();
    repeat (5) run_instr(mk(5'b11010, 3'd0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 2), 0), term);
    @(posedge clk); #1;
    n_cmp++; if (retired !== 16'd5) begin
      n_bad++; $display("FAIL wrap_retired16 got %0d want 5", retired);
    end
    n_cmp++; if (retired2 !== 2'd1) begin
      n_bad++; $display("FAIL wrap_retired2 got %0d want 1", retired2);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.mem_rdy = 1'b0; bus.opcode = 3'b000; bus.alu_op = 2'b00; bus.cond = 3'b000;
    bus.Z = 1'b0; bus.N = 1'b0; bus.V = 1'b0;
    test_reset();
    test_back_to_back();
    test_timeout();
    test_branch();
    test_illegal_halt();
    test_retired_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multicycle control FSM for the simple RISC datapath (register file, A/B/C pipeline registers, ALU, status flags, PC, data-address register, shared instruction/data RAM).
- Successor to the fixed controller. Adds a parametrised memory ready/timeout handshake, conditional branches, a sticky fault state for illegal encodings, and a retired-instruction counter.
- State is held in flops. Outputs are decoded from the registered state only; the BRANCH state additionally uses the status flags.

Parameters:
- RET_W, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_rdy before FAULT; 0 disables the timeout.
- BRANCH_EN, 1, when 0, opcode 001 is illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  3  IR[15:13].
- alu_op  in  2  IR[12:11].
- cond  in  3  IR[10:8], branch condition.
- Z, N, V  in  1 each  registered status flags.
- mem_rdy  in  1  memory completes the current request.
- waiting  out  1  high in RST, HALT and FAULT.
- reg_sel  out  2  00=Rm, 01=Rd, 10=Rn.
- wb_sel  out  2  00=C, 10=sximm8, 11=mem data.
- w_en, en_A, en_B, en_C, en_status, sel_A, sel_B  out  1 each  datapath controls; sel_A=1 zeroes A, sel_B=1 selects sximm5.
- clear_pc, load_pc, pc_src  out  1 each  pc_src: 0=PC+1, 1=branch target.
- load_ir, load_addr, sel_addr  out  1 each  sel_addr=1 puts PC on the address bus.
- mem_req, mem_we  out  1 each  memory request and write strobe.
- fault  out  1  sticky illegal-instruction or timeout flag.
- retired  out  RET_W  count of completed instructions.

Behaviour:
- Reset: rst sampled high sends state to RST at the next edge, from any state, including mid memory wait. In RST all outputs are 0 except waiting=1, clear_pc=1, load_pc=1. retired=0, fault=0, wait counter=0.
- Default: any output not listed for a state is 0.
- RST -> FETCH.
- FETCH: sel_addr=1, mem_req=1. Moves to LOAD_IR when mem_rdy=1.
- LOAD_IR: load_ir=1, load_pc=1, pc_src=0 -> DECODE.
- DECODE routing ({opcode,alu_op}):
  - 11010 -> WB_IMM.
  - 11000 (MOV reg) or 10111 (MVN) -> GET_B.
  - 10100 / 10101 / 10110 -> GET_A.
  - 01100 (LDR) or 10000 (STR) -> GET_A.
  - 111xx -> HALT.
  - 001xx -> BRANCH, if BRANCH_EN=1.
  - Everything else -> FAULT.
- GET_A: reg_sel=10, en_A=1. ALU ops -> GET_B; LDR/STR -> ADDR.
- GET_B: reg_sel=00, en_B=1 -> EXEC.
- EXEC: sel_A=1 for MOV reg/MVN.
  - CMP: en_status=1, en_C=0 -> FETCH, retire.
  - Otherwise: en_C=1 -> WB.
- WB: w_en=1, reg_sel=01, wb_sel=00 -> FETCH, retire.
- WB_IMM: w_en=1, reg_sel=10, wb_sel=10 -> FETCH, retire.
- ADDR: sel_B=1, en_C=1 -> LATCH.
- LATCH: load_addr=1. LDR -> MEM_RD; STR -> GET_D.
- MEM_RD: mem_req=1, sel_addr=0. On mem_rdy -> WB_MEM.
- WB_MEM: w_en=1, reg_sel=01, wb_sel=11 -> FETCH, retire.
- GET_D: reg_sel=01, en_B=1 -> PASS.
- PASS: sel_A=1, en_C=1 -> MEM_WR.
- MEM_WR: mem_req=1, mem_we=1. On mem_rdy -> FETCH, retire.
- BRANCH: condition taken is decided from the current Z/N/V.
  - cond 000 always; 001 Z; 010 !Z; 011 N^V; 100 (N^V)|Z.
  - Taken: load_pc=1, pc_src=1. Not taken: no PC update.
  - -> FETCH, retire.
  - cond 101-111 -> FAULT, no retire.
- HALT and FAULT: absorbing until rst; waiting=1; FAULT also drives fault=1. A pending mem_req is dropped.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Cleared on entry to each wait state; increments each cycle mem_rdy=0.
  - If MEM_TIMEOUT>0 and the count equals MEM_TIMEOUT with mem_rdy=0 -> FAULT.
  - mem_rdy=1 in the same cycle as the limit wins over the timeout.
- retired: increments by 1 on each retiring transition and wraps modulo 2^RET_W.

Test Plan:
- rst high for 2 cycles mid-MEM_RD -> next cycle state RST, waiting=1, mem_req=0, retired=0, fault=0; then FETCH with mem_req=1, sel_addr=1.
- MOV R1,#5 (11010), mem_rdy held high -> FETCH, LOAD_IR, DECODE, WB_IMM; w_en=1, wb_sel=10 in the 4th cycle; retired=1.
- ADD (10100) with mem_rdy=1 -> GET_A (reg_sel=10, en_A), GET_B, EXEC (en_C), WB (w_en, reg_sel=01); 7 cycles total; retired increments once.
- LDR with mem_rdy low for 3 cycles in MEM_RD, MEM_TIMEOUT=15 -> stays in MEM_RD 4 cycles, then WB_MEM with wb_sel=11; retired+1. Repeat with mem_rdy never high -> FAULT after 15 wait cycles; fault=1 sticky.
- BRANCH cond=001 with Z=1 -> load_pc=1, pc_src=1. Same with Z=0 -> load_pc=0. cond=110 -> FAULT.
- Encoding 000xx or HALT (111xx) -> FAULT (fault=1) or HALT (fault=0), waiting=1 in both, retired unchanged. With RET_W=2 and 5 retires -> retired=1.
